bcd_seven_seg_scan_driver: RTL and testbench
============================================

// Module: bcd_seven_seg_scan_driver
// PURPOSE
//  Multiplexed N-digit BCD to seven-segment display driver: the parametrised
//  successor to the single-digit combinational decoder. Latches a packed BCD
//  word through a valid/ready handshake into a shadow register. Swaps it into
//  the displayed register only at frame boundaries, so no tearing occurs. Time-
//  multiplexes digits onto one shared segment bus with dead time between digits.
//  Sits between the datapath that produces BCD values and the board's digit pins.
// PARAMETERS
//  NUM_DIGITS      4     digits scanned; >=1
//  SCAN_DIV        1000  clk cycles per digit slot; >=2
//  SEG_ACTIVE_LOW  0     1: invert seg outputs (common-anode parts)
//  DIG_ACTIVE_LOW  0     1: invert dig_en outputs
// PORTS
//  clk         in   1             system clock, rising edge
//  rst_n       in   1             asynchronous reset, active-low
//  bcd_in      in   4*NUM_DIGITS  packed BCD; [3:0] = digit 0 (least significant)
//  load_valid  in   1             bcd_in valid for capture
//  load_ready  out  1             shadow free; capture happens when valid&&ready
//  seg         out  7             {a,b,c,d,e,f,g}; seg[6]=a, seg[0]=g
//  dig_en      out  NUM_DIGITS    one-hot digit select; bit i drives digit i
//  bcd_err     out  1             displayed word holds a digit code > 9
// BEHAVIOUR
//  - Reset (async assert, sync release): cnt=0, idx=0, shadow=0, active=0,
//    pending=0. seg and dig_en are all inactive (polarity applied). bcd_err=0.
//  - load_ready = !pending (combinational). On valid&&ready: shadow<=bcd_in, pending<=1.
//  - cnt counts 0..SCAN_DIV-1 and wraps. On wrap, idx advances; idx wraps
//    NUM_DIGITS-1 -> 0. Frame boundary = cnt and idx both at terminal count.
//  - At frame boundary with pending=1: active<=shadow, pending<=0. bcd_err is
//    recomputed from the new active word.
//  - Capture in the same cycle as a boundary (pending was 0): value goes into
//    shadow. It is shown from the following boundary; nothing is lost.
//  - Registered outputs, 1-cycle latency from cnt/idx. dig_en[idx] is active
//    only for cnt in 1..SCAN_DIV-1. cnt==0 is dead time: all digits off, which
//    prevents ghosting. seg holds the decode of active digit idx.
//  - Decode, with segments lit per digit:
//    0 abcdef, 1 bc, 2 abdeg, 3 abcdg, 4 bcfg, 5 acdfg, 6 acdefg, 7 abc,
//    8 abcdefg, 9 abcdfg. Codes 10-15 blank the digit (all off) and set bcd_err.
//  - NUM_DIGITS=1: idx is fixed at 0. Every cnt wrap is a frame boundary.
//  - rst_n asserted mid-frame or with a pending load: the pending value is
//    discarded and all state returns to reset values immediately.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN
//   defined: starting from digit NUM_DIGITS-1 downward, each digit is blanked
//    (seg all off, dig_en still scanned) while it and every higher digit are 0.
//    Digit 0 is never blanked. An invalid code (>9) ends the zero run.
//   undefined: every digit is displayed, including leading zeros.
// TESTING (NUM_DIGITS=4, SCAN_DIV=4, both polarities 0 unless stated)
//  1. Reset then idle 20 clk -> seg=7'h7E ("0") while digit enabled.
//     dig_en sequence 0001,0010,0100,1000 repeats; 0000 on each cnt==0 cycle.
//  2. Load 16'h1234 mid-frame -> load_ready=0 until the boundary.
//     Next frame: digit0 seg=7'h33, digit1 7'h79, digit2 7'h6D, digit3 7'h30.
//  3. Load 16'h0000, then 16'h5678 on the cycle pending clears -> frame N shows
//     0000. Frame N+1 shows 5678 (5=7'h5B, 6=7'h5F, 7=7'h70, 8=7'h7F).
//  4. Load 16'h00A9 -> digit1 blank (seg=0), digit0 seg=7'h7B, bcd_err=1.
//     Load 16'h0009 -> bcd_err=0 after the following boundary.
//  5. LEADING_ZERO_BLANK_EN, load 16'h0050 -> digits 3,2 blank; digit1 7'h5B;
//     digit0 7'h7E. Load 16'h0000 -> only digit0 lit.
//  6. SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1: assert rst_n=0 mid-frame with pending
//     -> seg=7'h7F, dig_en=4'hF immediately; load_ready=1 after release.

Source files
------------

// File: rtl/bcd_seven_seg_scan_driver.sv
// bcd_seven_seg_scan_driver: multiplexed N-digit BCD to seven-segment scan driver with tear-free frame swap.
//   clk, rst_n        system clock; asynchronous active-low reset
//   bcd_in            packed BCD word, [3:0] is digit 0
//   load_valid/ready  capture handshake into the shadow register
//   seg               {a,b,c,d,e,f,g} of the digit being scanned
//   dig_en            one-hot digit select, off during each slot's first cycle
//   bcd_err           displayed word holds a code above 9
//   LEADING_ZERO_BLANK_EN: when defined, blanks leading zero digits (digit 0 always shown)
module bcd_seven_seg_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    load_valid,
    output logic                    load_ready,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    bcd_err
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW != 0 ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW != 0 ? '1 : '0;

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] shadow, active;
    logic                    pending;
    logic [3:0]              digits [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   bad, blank, dig_nxt;
    logic [6:0]              seg_nxt;
    logic                    cnt_wrap, frame;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h7E;
            4'd1:    seg7 = 7'h30;
            4'd2:    seg7 = 7'h6D;
            4'd3:    seg7 = 7'h79;
            4'd4:    seg7 = 7'h33;
            4'd5:    seg7 = 7'h5B;
            4'd6:    seg7 = 7'h5F;
            4'd7:    seg7 = 7'h70;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h7B;
            default: seg7 = 7'h00;
        endcase
    endfunction

    genvar i;
    generate
        for (i = 0; i < NUM_DIGITS; i++) begin : g_dig
            assign digits[i] = active[4*i +: 4];
            assign bad[i]    = shadow[4*i +: 4] > 4'd9;
`ifdef LEADING_ZERO_BLANK_EN
            // A digit is leading-zero when it and every digit above it is zero;
            // any code above 9 is non-zero and therefore ends the run.
            if (i == 0) begin : g_lo
                assign blank[i] = 1'b0;
            end else begin : g_hi
                assign blank[i] = active[4*NUM_DIGITS-1:4*i] == '0;
            end
`else
            assign blank[i] = 1'b0;
`endif
        end
    endgenerate

    assign load_ready = !pending;
    assign cnt_wrap   = cnt == CNT_LAST;
    assign frame      = cnt_wrap && (idx == IDX_LAST);

    always_comb begin
        seg_nxt = blank[idx] ? 7'h00 : seg7(digits[idx]);
        dig_nxt = (cnt != '0) ? NUM_DIGITS'(1) << idx : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            idx     <= '0;
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
            seg     <= SEG_OFF;
            dig_en  <= DIG_OFF;
            bcd_err <= 1'b0;
        end else begin
            cnt <= cnt_wrap ? '0 : cnt + CW'(1);
            if (cnt_wrap)
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            // Pending blocks capture, so swap and capture never coincide.
            if (frame && pending) begin
                active  <= shadow;
                pending <= 1'b0;
                bcd_err <= |bad;
            end else if (load_valid && !pending) begin
                shadow  <= bcd_in;
                pending <= 1'b1;
            end
            seg    <= seg_nxt ^ SEG_OFF;
            dig_en <= dig_nxt ^ DIG_OFF;
        end
    end
endmodule

// File: tb/tb_bcd_seven_seg_scan_driver.sv
// tb_bcd_seven_seg_scan_driver: checks the scan driver in both output polarities against a time-based model.
module tb_bcd_seven_seg_scan_driver;
    localparam int N = 4;
    localparam int S = 4;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bcd_in = '0;
    logic        load_valid = 1'b0;
    logic        rdy_a, rdy_b, err_a, err_b;
    logic [6:0]  seg_a, seg_b;
    logic [3:0]  dig_a, dig_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bcd_seven_seg_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(S), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) u_a (
        .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .load_valid(load_valid),
        .load_ready(rdy_a), .seg(seg_a), .dig_en(dig_a), .bcd_err(err_a));

    bcd_seven_seg_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(S), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) u_b (
        .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .load_valid(load_valid),
        .load_ready(rdy_b), .seg(seg_b), .dig_en(dig_b), .bcd_err(err_b));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: display position derived from cycles elapsed since reset release.
    logic [6:0]  tbl [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
    logic [15:0] m_active = '0, m_shadow = '0;
    logic        m_pending = 1'b0;
    logic [6:0]  exp_seg = '0;
    logic [3:0]  exp_dig = '0;
    logic        exp_err = 1'b0, exp_ready = 1'b1;
    int          t = 0;

    function automatic logic has_bad(input logic [15:0] w);
        for (int k = 0; k < N; k++)
            if (w[4*k +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            t = 0; m_active = '0; m_shadow = '0; m_pending = 1'b0;
            exp_seg = '0; exp_dig = '0; exp_err = 1'b0; exp_ready = 1'b1;
        end else begin
            int p, d;
            logic [3:0] v;
            logic cap;
            p = t % (N*S);
            d = p / S;
            v = 4'((m_active >> (4*d)) & 16'hF);
            exp_dig = (p % S != 0) ? 4'(1 << d) : 4'h0;
            exp_seg = (v > 9 || (LZ && d != 0 && (m_active >> (4*d)) == 0)) ? 7'h00 : tbl[v];
            cap = load_valid && !m_pending;
            if (p == N*S-1 && m_pending) begin
                m_active = m_shadow; m_pending = 1'b0; exp_err = has_bad(m_shadow);
            end else if (cap) begin
                m_shadow = bcd_in; m_pending = 1'b1;
            end
            exp_ready = !m_pending;
            t++;
        end
    end

    initial forever begin
        @(negedge clk);
        check("seg_a", seg_a, exp_seg);
        check("dig_a", dig_a, exp_dig);
        check("err_a", err_a, exp_err);
        check("rdy_a", rdy_a, exp_ready);
        check("seg_b", seg_b, exp_seg ^ 7'h7F);
        check("dig_b", dig_b, exp_dig ^ 4'hF);
        check("err_b", err_b, exp_err);
        check("rdy_b", rdy_b, exp_ready);
    end

    task automatic load(input logic [15:0] v);
        @(negedge clk);
        bcd_in = v;
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!rdy_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rdy_a) check("ready_timeout", 0, 1);
    endtask

    task automatic frame_lit(input logic [6:0] l0, l1, l2, l3);
        logic [6:0] lit [4];
        int on = 0;
        lit = '{l0, l1, l2, l3};
        repeat (N*S) begin
            @(negedge clk);
            load_valid = 1'b0;
            if (dig_a != 0) on++;
            for (int d = 0; d < N; d++)
                if (dig_a == 4'(1 << d)) check("frame_seg", seg_a, lit[d]);
        end
        check("frame_slots", on, N*(S-1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [6:0] z;
        z = LZ ? 7'h00 : 7'h7E;
        repeat (3) @(negedge clk);
        check("rst_seg_a", seg_a, 7'h00);
        check("rst_dig_b", dig_b, 4'hF);
        rst_n = 1'b1;
        frame_lit(7'h7E, z, z, z);
        repeat (4) @(negedge clk);

        load(16'h1234);
        check("pending_ready", rdy_a, 1'b0);
        wait_ready();
        frame_lit(7'h33, 7'h79, 7'h6D, 7'h30);

        load(16'h0000);
        wait_ready();
        bcd_in = 16'h5678;
        load_valid = 1'b1;
        frame_lit(7'h7E, z, z, z);
        frame_lit(7'h7F, 7'h70, 7'h5F, 7'h5B);

        load(16'h00A9);
        wait_ready();
        check("err_set", err_a, 1'b1);
        frame_lit(7'h7B, 7'h00, z, z);
        load(16'h0009);
        check("err_hold", err_a, 1'b1);
        wait_ready();
        check("err_clr", err_a, 1'b0);

        load(16'h0050);
        wait_ready();
        frame_lit(7'h7E, 7'h5B, z, z);
        load(16'h0000);
        wait_ready();
        frame_lit(7'h7E, z, z, z);

        load(16'h1111);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_seg_b", seg_b, 7'h7F);
        check("arst_dig_b", dig_b, 4'hF);
        check("arst_seg_a", seg_a, 7'h00);
        check("arst_dig_a", dig_a, 4'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rel_ready", rdy_b, 1'b1);
        frame_lit(7'h7E, z, z, z);
        frame_lit(7'h7E, z, z, z);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
